// File: rtl/inst_decode_stage_pkg.sv
// Shared RV32 decode definitions: opcodes, funct7 values, ALU op encodings and the decoded bundle.
package inst_decode_stage_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned OPC_W    = 7;
  localparam int unsigned F3_W     = 3;

  localparam logic [OPC_W-1:0] OPC_LUI    = 7'b0110111;
  localparam logic [OPC_W-1:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [OPC_W-1:0] OPC_JAL    = 7'b1101111;
  localparam logic [OPC_W-1:0] OPC_JALR   = 7'b1100111;
  localparam logic [OPC_W-1:0] OPC_BRANCH = 7'b1100011;
  localparam logic [OPC_W-1:0] OPC_LOAD   = 7'b0000011;
  localparam logic [OPC_W-1:0] OPC_STORE  = 7'b0100011;
  localparam logic [OPC_W-1:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [OPC_W-1:0] OPC_OP     = 7'b0110011;
  localparam logic [OPC_W-1:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [6:0] F7_BASE = 7'h00;
  localparam logic [6:0] F7_ALT  = 7'h20;

  localparam logic [F3_W-1:0] F3_ADD_SUB = 3'b000;
  localparam logic [F3_W-1:0] F3_SLL     = 3'b001;
  localparam logic [F3_W-1:0] F3_SRL_SRA = 3'b101;

  localparam logic [XLEN-1:0] INST_NOP    = 32'h0000_0013;
  localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;
  localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD    = 4'd0,
    ALU_SUB    = 4'd1,
    ALU_SLL    = 4'd2,
    ALU_SLT    = 4'd3,
    ALU_SLTU   = 4'd4,
    ALU_XOR    = 4'd5,
    ALU_SRL    = 4'd6,
    ALU_SRA    = 4'd7,
    ALU_OR     = 4'd8,
    ALU_AND    = 4'd9,
    ALU_PASS_B = 4'd10
  } alu_op_e;

  // Control bundle handed to the execute stage
  typedef struct packed {
    logic [REG_AW-1:0] rs1;
    logic [REG_AW-1:0] rs2;
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   imm;
    alu_op_e           alu_op;
    logic              src_a_pc;
    logic              src_b_imm;
    logic              rf_wen;
    logic              mem_ren;
    logic              mem_wen;
    logic [F3_W-1:0]   funct3;
    logic              branch;
    logic              jal;
    logic              jalr;
    logic              ebreak;
    logic              illegal;
  } decode_t;

  // Arithmetic op from funct3; alt selects SUB/SRA where that variant exists
  function automatic alu_op_e alu_from_funct3(input logic [F3_W-1:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/inst_decode_stage_imm_gen.sv
// Immediate generator: sign-extended 32-bit immediate selected by the instruction format.
module inst_decode_stage_imm_gen
  import inst_decode_stage_pkg::*;
(
  input  logic [XLEN-1:0] inst,
  output logic [XLEN-1:0] imm
);

  logic [OPC_W-1:0] opcode;

  assign opcode = inst[OPC_W-1:0];

  // R-type and unrecognised opcodes carry no immediate
  always_comb begin
    imm = '0;
    case (opcode)
      OPC_LUI, OPC_AUIPC:
        imm = {inst[31:12], 12'h000};
      OPC_JAL:
        imm = {{12{inst[31]}}, inst[19:12], inst[20], inst[30:21], 1'b0};
      OPC_BRANCH:
        imm = {{20{inst[31]}}, inst[7], inst[30:25], inst[11:8], 1'b0};
      OPC_STORE:
        imm = {{21{inst[31]}}, inst[30:25], inst[11:7]};
      OPC_JALR, OPC_LOAD, OPC_OP_IMM, OPC_SYSTEM:
        imm = {{21{inst[31]}}, inst[30:20]};
      default:
        imm = '0;
    endcase
  end

endmodule

// File: rtl/inst_decode_stage.sv
// RV32 decode stage: one-entry skid-free pipeline register with combinational decode of the held word.
// Optional RV32E_REGS_EN: register indices >= 16 used by the format make the instruction illegal.
module inst_decode_stage
  import inst_decode_stage_pkg::*;
(
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [XLEN-1:0]     in_inst,
  input  logic [XLEN-1:0]     in_pc,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [XLEN-1:0]     out_pc,
  output logic [REG_AW-1:0]   out_rs1,
  output logic [REG_AW-1:0]   out_rs2,
  output logic [REG_AW-1:0]   out_rd,
  output logic [XLEN-1:0]     out_imm,
  output logic [ALU_OP_W-1:0] out_alu_op,
  output logic                out_src_a_pc,
  output logic                out_src_b_imm,
  output logic                out_rf_wen,
  output logic                out_mem_ren,
  output logic                out_mem_wen,
  output logic [F3_W-1:0]     out_funct3,
  output logic                out_branch,
  output logic                out_jal,
  output logic                out_jalr,
  output logic                out_ebreak,
  output logic                out_illegal
);

  logic            full_q;
  logic [XLEN-1:0] inst_q;
  logic [XLEN-1:0] pc_q;
  logic            accept;
  logic            drain;

  assign in_ready  = !flush && (!full_q || out_ready);
  assign out_valid = full_q;
  assign accept    = in_valid && in_ready;
  assign drain     = full_q && out_ready;

  // Held word stays put on drain/flush so the decoded outputs never glitch to garbage
  always_ff @(posedge clock) begin
    if (reset) begin
      full_q <= 1'b0;
      inst_q <= INST_NOP;
      pc_q   <= '0;
    end else if (flush) begin
      full_q <= 1'b0;
    end else if (accept) begin
      full_q <= 1'b1;
      inst_q <= in_inst;
      pc_q   <= in_pc;
    end else if (drain) begin
      full_q <= 1'b0;
    end
  end

  logic [OPC_W-1:0]  opcode;
  logic [REG_AW-1:0] rs1_f;
  logic [REG_AW-1:0] rs2_f;
  logic [REG_AW-1:0] rd_f;
  logic [F3_W-1:0]   funct3;
  logic [6:0]        funct7;
  logic [XLEN-1:0]   imm;

  assign opcode = inst_q[6:0];
  assign rd_f   = inst_q[11:7];
  assign funct3 = inst_q[14:12];
  assign rs1_f  = inst_q[19:15];
  assign rs2_f  = inst_q[24:20];
  assign funct7 = inst_q[31:25];

  inst_decode_stage_imm_gen u_imm_gen (
    .inst (inst_q),
    .imm  (imm)
  );

  decode_t dec;
  logic    use_rs1;
  logic    use_rs2;
  logic    use_rd;

  // Register fields the format does not use are reported as x0 so hazard logic can ignore them
  always_comb begin
    dec        = '0;
    dec.alu_op = ALU_ADD;
    dec.funct3 = funct3;
    dec.imm    = imm;
    use_rs1    = 1'b0;
    use_rs2    = 1'b0;
    use_rd     = 1'b0;

    case (opcode)
      OPC_LUI: begin
        use_rd        = 1'b1;
        dec.alu_op    = ALU_PASS_B;
        dec.src_b_imm = 1'b1;
        dec.rf_wen    = 1'b1;
      end
      OPC_AUIPC: begin
        use_rd        = 1'b1;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.rf_wen    = 1'b1;
      end
      OPC_JAL: begin
        use_rd        = 1'b1;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.rf_wen    = 1'b1;
        dec.jal       = 1'b1;
      end
      OPC_JALR: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        dec.src_a_pc  = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.rf_wen    = 1'b1;
        dec.jalr      = 1'b1;
      end
      OPC_BRANCH: begin
        use_rs1    = 1'b1;
        use_rs2    = 1'b1;
        dec.branch = 1'b1;
      end
      OPC_LOAD: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.rf_wen    = 1'b1;
        dec.mem_ren   = 1'b1;
      end
      OPC_STORE: begin
        use_rs1       = 1'b1;
        use_rs2       = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.mem_wen   = 1'b1;
      end
      OPC_OP_IMM: begin
        use_rd        = 1'b1;
        use_rs1       = 1'b1;
        dec.src_b_imm = 1'b1;
        dec.rf_wen    = 1'b1;
        // funct7 is only an opcode extension for the shift immediates
        dec.alu_op    = alu_from_funct3(funct3, (funct3 == F3_SRL_SRA) && (funct7 == F7_ALT));
        if (funct3 == F3_SLL) begin
          dec.illegal = (funct7 != F7_BASE);
        end else if (funct3 == F3_SRL_SRA) begin
          dec.illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
        end
      end
      OPC_OP: begin
        use_rd      = 1'b1;
        use_rs1     = 1'b1;
        use_rs2     = 1'b1;
        dec.rf_wen  = 1'b1;
        dec.imm     = '0;
        dec.alu_op  = alu_from_funct3(funct3, funct7 == F7_ALT);
        dec.illegal = !((funct7 == F7_BASE) ||
                        ((funct7 == F7_ALT) &&
                         ((funct3 == F3_ADD_SUB) || (funct3 == F3_SRL_SRA))));
      end
      OPC_SYSTEM: begin
        if (inst_q == INST_EBREAK) begin
          dec.ebreak = 1'b1;
        end else if (inst_q != INST_ECALL) begin
          dec.illegal = 1'b1;
        end
      end
      default: begin
        dec.illegal = 1'b1;
      end
    endcase

`ifdef RV32E_REGS_EN
    if ((use_rs1 && rs1_f[REG_AW-1]) || (use_rs2 && rs2_f[REG_AW-1]) ||
        (use_rd && rd_f[REG_AW-1])) begin
      dec.illegal = 1'b1;
    end
`endif

    dec.rs1 = use_rs1 ? rs1_f : '0;
    dec.rs2 = use_rs2 ? rs2_f : '0;
    dec.rd  = use_rd  ? rd_f  : '0;

    // An illegal word must not have any architectural side effect
    if (dec.illegal) begin
      dec.rf_wen  = 1'b0;
      dec.mem_ren = 1'b0;
      dec.mem_wen = 1'b0;
      dec.branch  = 1'b0;
      dec.jal     = 1'b0;
      dec.jalr    = 1'b0;
    end
    if (dec.rd == '0) begin
      dec.rf_wen = 1'b0;
    end
  end

  assign out_pc        = pc_q;
  assign out_rs1       = dec.rs1;
  assign out_rs2       = dec.rs2;
  assign out_rd        = dec.rd;
  assign out_imm       = dec.imm;
  assign out_alu_op    = dec.alu_op;
  assign out_src_a_pc  = dec.src_a_pc;
  assign out_src_b_imm = dec.src_b_imm;
  assign out_rf_wen    = dec.rf_wen;
  assign out_mem_ren   = dec.mem_ren;
  assign out_mem_wen   = dec.mem_wen;
  assign out_funct3    = dec.funct3;
  assign out_branch    = dec.branch;
  assign out_jal       = dec.jal;
  assign out_jalr      = dec.jalr;
  assign out_ebreak    = dec.ebreak;
  assign out_illegal   = dec.illegal;

endmodule

// File: tb/tb_inst_decode_stage.sv
// Self-checking bench for inst_decode_stage: directed vector table, handshake corner sequences, random traffic.
module tb_inst_decode_stage;

  localparam logic [31:0] NOP      = 32'h0000_0013;
  localparam logic [9:0]  MASK_ALL = 10'b11_1111_1111;
  // illegal words: only the illegal flag and the forced-off side effects are defined
  localparam logic [9:0]  MASK_ILL = 10'b00_1111_1101;
  localparam int ALU_TAB [8] = '{0, 2, 3, 4, 5, 6, 8, 9};

  logic        clock = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [31:0] out_imm;
  logic [3:0]  out_alu_op;
  logic        out_src_a_pc, out_src_b_imm, out_rf_wen, out_mem_ren, out_mem_wen;
  logic [2:0]  out_funct3;
  logic        out_branch, out_jal, out_jalr, out_ebreak, out_illegal;

  always #5 clock = ~clock;

  inst_decode_stage dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_imm(out_imm),
    .out_alu_op(out_alu_op), .out_src_a_pc(out_src_a_pc), .out_src_b_imm(out_src_b_imm),
    .out_rf_wen(out_rf_wen), .out_mem_ren(out_mem_ren), .out_mem_wen(out_mem_wen),
    .out_funct3(out_funct3), .out_branch(out_branch), .out_jal(out_jal),
    .out_jalr(out_jalr), .out_ebreak(out_ebreak), .out_illegal(out_illegal)
  );

  // flag order: src_a_pc src_b_imm rf_wen mem_ren mem_wen branch jal jalr ebreak illegal
  logic [9:0] dut_flags;
  assign dut_flags = {out_src_a_pc, out_src_b_imm, out_rf_wen, out_mem_ren, out_mem_wen,
                      out_branch, out_jal, out_jalr, out_ebreak, out_illegal};

  typedef struct packed {
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [9:0]  flags;
  } dec_t;

  typedef struct {
    logic [31:0] inst;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [31:0] imm;
    logic [3:0]  alu;
    logic [9:0]  flags;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic        m_full;
  logic [31:0] m_inst;
  logic [31:0] m_pc;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference decoder written from the ISA field definitions
  function automatic dec_t ref_decode(input logic [31:0] i);
    dec_t d;
    int v;
    logic [6:0] op, f7;
    logic [2:0] f3;
    logic ur1, ur2, urd, sa, sb, wen, mr, mw, br, jl, jr, eb, il;
    op = i[6:0]; f3 = i[14:12]; f7 = i[31:25];
    d = '0; v = 0;
    {ur1, ur2, urd, sa, sb, wen, mr, mw, br, jl, jr, eb, il} = '0;
    case (op)
      7'h37: begin urd = 1; sb = 1; wen = 1; d.alu = 4'd10; end
      7'h17: begin urd = 1; sa = 1; sb = 1; wen = 1; end
      7'h6F: begin
        urd = 1; sa = 1; sb = 1; wen = 1; jl = 1;
        v = int'(i[19:12]) * 4096 + int'(i[20]) * 2048 + int'(i[30:21]) * 2 - (i[31] ? 1048576 : 0);
      end
      7'h67: begin
        urd = 1; ur1 = 1; sa = 1; sb = 1; wen = 1; jr = 1;
        v = int'(i[30:20]) - (i[31] ? 2048 : 0);
      end
      7'h63: begin
        ur1 = 1; ur2 = 1; br = 1;
        v = int'(i[7]) * 2048 + int'(i[30:25]) * 32 + int'(i[11:8]) * 2 - (i[31] ? 4096 : 0);
      end
      7'h03: begin
        urd = 1; ur1 = 1; sb = 1; wen = 1; mr = 1;
        v = int'(i[30:20]) - (i[31] ? 2048 : 0);
      end
      7'h23: begin
        ur1 = 1; ur2 = 1; sb = 1; mw = 1;
        v = int'(i[30:25]) * 32 + int'(i[11:7]) - (i[31] ? 2048 : 0);
      end
      7'h13: begin
        urd = 1; ur1 = 1; sb = 1; wen = 1;
        v = int'(i[30:20]) - (i[31] ? 2048 : 0);
        d.alu = 4'(ALU_TAB[f3]);
        if (f3 == 3'd1 && f7 != 7'h00) il = 1;
        if (f3 == 3'd5) begin
          if (f7 == 7'h20) d.alu = 4'd7;
          else if (f7 != 7'h00) il = 1;
        end
      end
      7'h33: begin
        urd = 1; ur1 = 1; ur2 = 1; wen = 1;
        if (f7 == 7'h00) d.alu = 4'(ALU_TAB[f3]);
        else if (f7 == 7'h20 && f3 == 3'd0) d.alu = 4'd1;
        else if (f7 == 7'h20 && f3 == 3'd5) d.alu = 4'd7;
        else il = 1;
      end
      7'h73: begin
        v = int'(i[30:20]) - (i[31] ? 2048 : 0);
        if (i == 32'h0010_0073) eb = 1;
        else if (i != 32'h0000_0073) il = 1;
      end
      default: il = 1;
    endcase
    d.imm = (op == 7'h37 || op == 7'h17) ? (i & 32'hFFFF_F000) : 32'(v);
    d.rs1 = ur1 ? i[19:15] : 5'd0;
    d.rs2 = ur2 ? i[24:20] : 5'd0;
    d.rd  = urd ? i[11:7]  : 5'd0;
`ifdef RV32E_REGS_EN
    if (d.rs1 >= 5'd16 || d.rs2 >= 5'd16 || d.rd >= 5'd16) il = 1;
`endif
    if (il) {wen, mr, mw, br, jl, jr} = '0;
    if (d.rd == 5'd0) wen = 0;
    d.flags = {sa, sb, wen, mr, mw, br, jl, jr, eb, il};
    return d;
  endfunction

  task automatic check_model();
    dec_t e;
    e = ref_decode(m_inst);
    chk("out_valid", 32'(out_valid), 32'(m_full));
    chk("in_ready", 32'(in_ready), 32'(!flush && (!m_full || out_ready)));
    chk("out_pc", out_pc, m_pc);
    chk("funct3", 32'(out_funct3), 32'(m_inst[14:12]));
    chk("ctl_forced", 32'(dut_flags & MASK_ILL), 32'(e.flags & MASK_ILL));
    if (!e.flags[0]) begin
      chk("rs1", 32'(out_rs1), 32'(e.rs1));
      chk("rs2", 32'(out_rs2), 32'(e.rs2));
      chk("rd", 32'(out_rd), 32'(e.rd));
      chk("imm", out_imm, e.imm);
      chk("alu_op", 32'(out_alu_op), 32'(e.alu));
      chk("flags", 32'(dut_flags), 32'(e.flags));
    end
  endtask

  // Starts and ends at a falling edge; checks the current state, then advances one clock
  task automatic step(input logic rst, input logic v, input logic [31:0] inst,
                      input logic [31:0] pc, input logic fl, input logic rdy);
    logic rdy_m;
    reset = rst; in_valid = v; in_inst = inst; in_pc = pc; flush = fl; out_ready = rdy;
    #1;
    check_model();
    @(posedge clock);
    rdy_m = !fl && (!m_full || rdy);
    if (rst) begin
      m_full = 0; m_inst = NOP; m_pc = 0;
    end else if (fl) begin
      m_full = 0;
    end else if (v && rdy_m) begin
      m_full = 1; m_inst = inst; m_pc = pc;
    end else if (m_full && rdy) begin
      m_full = 0;
    end
    @(negedge clock);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] r;
    int unsigned k;
    logic [6:0] opcs [10];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h73};
    r = $urandom;
    k = $urandom_range(0, 15);
    if (k < 10) r[6:0] = opcs[k];
    else if (k == 10) r = 32'h0010_0073;
    else if (k == 11) r = 32'h0000_0073;
    else if (k == 12) begin r[6:0] = 7'h33; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
    else if (k == 13) begin r[6:0] = 7'h13; r[31:25] = ($urandom_range(0, 1) != 0) ? 7'h20 : 7'h00; end
    if ($urandom_range(0, 1) != 0) begin r[24] = 1'b0; r[19] = 1'b0; r[11] = 1'b0; end
    return r;
  endfunction

  vec_t vecs[$];

  initial begin
    vecs.push_back('{32'h0050_0093, 5'd0, 5'd0, 5'd1, 32'd5,          4'd0,  10'b0110000000});
    vecs.push_back('{32'hFE20_8EE3, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFC,   4'd0,  10'b0000010000});
    vecs.push_back('{32'h1234_52B7, 5'd0, 5'd0, 5'd5, 32'h1234_5000,   4'd10, 10'b0110000000});
`ifdef RV32E_REGS_EN
    vecs.push_back('{32'h0000_0833, 5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  10'b0000000001});
`else
    vecs.push_back('{32'h0000_0833, 5'd0, 5'd0, 5'd16, 32'd0,         4'd0,  10'b0010000000});
`endif
    vecs.push_back('{32'h0010_0073, 5'd0, 5'd0, 5'd0, 32'd1,          4'd0,  10'b0000000010});
    vecs.push_back('{32'h4020_81B3, 5'd1, 5'd2, 5'd3, 32'd0,          4'd1,  10'b0010000000});
    vecs.push_back('{32'h4032_5213, 5'd4, 5'd0, 5'd4, 32'h0000_0403,   4'd7,  10'b0110000000});
    vecs.push_back('{32'h4000_E133, 5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  10'b0000000001});
    vecs.push_back('{32'h0020_A423, 5'd1, 5'd2, 5'd0, 32'd8,          4'd0,  10'b0100100000});
    vecs.push_back('{32'hFFC0_A283, 5'd1, 5'd0, 5'd5, 32'hFFFF_FFFC,   4'd0,  10'b0111000000});
    vecs.push_back('{32'h0080_00EF, 5'd0, 5'd0, 5'd1, 32'd8,          4'd0,  10'b1110001000});
    vecs.push_back('{32'h0000_007F, 5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  10'b0000000001});
    vecs.push_back('{32'h0000_1397, 5'd0, 5'd0, 5'd7, 32'h0000_1000,   4'd0,  10'b1110000000});
    vecs.push_back('{32'h0010_0013, 5'd0, 5'd0, 5'd0, 32'd1,          4'd0,  10'b0100000000});
    vecs.push_back('{32'h0000_0073, 5'd0, 5'd0, 5'd0, 32'd0,          4'd0,  10'b0000000000});
    vecs.push_back('{32'h0001_00E7, 5'd2, 5'd0, 5'd1, 32'd0,          4'd0,  10'b1110000100});

    reset = 1; in_valid = 0; in_inst = 0; in_pc = 0; flush = 0; out_ready = 0;
    repeat (2) @(posedge clock);
    m_full = 0; m_inst = NOP; m_pc = 0;
    @(negedge clock);

    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_pc", out_pc, 32'd0);
    chk("rst_imm", out_imm, 32'd0);
    chk("rst_alu", 32'(out_alu_op), 32'd0);
    chk("rst_flags", 32'(dut_flags), 32'(10'b0100000000));

    // Directed table with out_ready held high: one instruction per cycle, no bubbles
    foreach (vecs[k]) begin
      step(0, 1, vecs[k].inst, 32'h8000_0000 + 32'(k) * 4, 0, 1);
      chk($sformatf("vec%0d_valid", k), 32'(out_valid), 32'd1);
      chk($sformatf("vec%0d_pc", k), out_pc, 32'h8000_0000 + 32'(k) * 4);
      if (vecs[k].flags[0]) begin
        chk($sformatf("vec%0d_ctl", k), 32'(dut_flags & MASK_ILL), 32'(vecs[k].flags & MASK_ILL));
      end else begin
        chk($sformatf("vec%0d_rs1", k), 32'(out_rs1), 32'(vecs[k].rs1));
        chk($sformatf("vec%0d_rs2", k), 32'(out_rs2), 32'(vecs[k].rs2));
        chk($sformatf("vec%0d_rd", k), 32'(out_rd), 32'(vecs[k].rd));
        chk($sformatf("vec%0d_imm", k), out_imm, vecs[k].imm);
        chk($sformatf("vec%0d_alu", k), 32'(out_alu_op), 32'(vecs[k].alu));
        chk($sformatf("vec%0d_flags", k), 32'(dut_flags & MASK_ALL), 32'(vecs[k].flags));
      end
    end
    step(0, 0, 32'h0, 32'h0, 0, 1);

    // Backpressure: held bundle stays stable, then drain+accept in the same cycle
    step(0, 1, 32'h0050_0093, 32'h0000_0100, 0, 0);
    step(0, 1, 32'h1234_52B7, 32'h0000_0104, 0, 0);
    chk("bp_in_ready", 32'(in_ready), 32'd0);
    chk("bp_pc_hold", out_pc, 32'h0000_0100);
    chk("bp_imm_hold", out_imm, 32'd5);
    step(0, 1, 32'h1234_52B7, 32'h0000_0104, 0, 0);
    chk("bp_pc_hold2", out_pc, 32'h0000_0100);
    step(0, 1, 32'h1234_52B7, 32'h0000_0104, 0, 1);
    chk("nobubble_valid", 32'(out_valid), 32'd1);
    chk("nobubble_pc", out_pc, 32'h0000_0104);
    chk("nobubble_alu", 32'(out_alu_op), 32'd10);

    // Flush with a full register and a valid incoming word
    step(0, 1, 32'h0020_A423, 32'h0000_0200, 1, 0);
    chk("flush_valid", 32'(out_valid), 32'd0);
    chk("flush_pc_kept", out_pc, 32'h0000_0104);
    chk("flush_in_ready", 32'(in_ready), 32'd0);
    step(0, 0, 32'h0, 32'h0, 0, 0);
    chk("flush_stays_empty", 32'(out_valid), 32'd0);

    // Reset while holding an instruction under backpressure
    step(0, 1, 32'h0080_00EF, 32'h0000_0300, 0, 0);
    step(1, 1, 32'hFFC0_A283, 32'h0000_0304, 0, 0);
    chk("rst_mid_valid", 32'(out_valid), 32'd0);
    chk("rst_mid_pc", out_pc, 32'd0);
    chk("rst_mid_flags", 32'(dut_flags), 32'(10'b0100000000));

    for (int n = 0; n < 800; n++) begin
      step(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0), rand_inst(),
           $urandom & 32'hFFFF_FFFC, ($urandom_range(0, 15) == 0), ($urandom_range(0, 2) != 0));
    end
    step(0, 0, 32'h0, 32'h0, 0, 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/inst_decode_stage.md
# inst_decode_stage

Decode stage between the instruction fetch unit and the execute unit of the single-issue RV32 core. Accepts one fetched instruction plus its PC over a valid/ready handshake, holds it in a one-entry pipeline register, and presents a decoded control bundle to the execute stage under its own valid/ready handshake. Supports a flush from branch/jump redirect.

## Interface
- No parameters.
- clock  in  1  clock
- reset  in  1  reset, synchronous, active-high
- in_valid  in  1  fetch has instruction
- in_ready  out  1  stage can accept
- in_inst  in  32  instruction word
- in_pc  in  32  instruction address
- flush  in  1  discard held and incoming instruction
- out_valid  out  1  decoded bundle valid
- out_ready  in  1  execute accepts bundle
- out_pc  out  32  held PC
- out_rs1 / out_rs2 / out_rd  out  5 each  register indices
- out_imm  out  32  sign-extended immediate
- out_alu_op  out  4  0 ADD,1 SUB,2 SLL,3 SLT,4 SLTU,5 XOR,6 SRL,7 SRA,8 OR,9 AND,10 PASS_B
- out_src_a_pc  out  1  ALU operand A is PC (AUIPC, JAL, JALR link)
- out_src_b_imm  out  1  ALU operand B is immediate
- out_rf_wen  out  1  writes rd (forced 0 when rd==0)
- out_mem_ren / out_mem_wen  out  1 each  load / store
- out_funct3  out  3  memory size/sign or branch condition
- out_branch / out_jal / out_jalr  out  1 each  control-flow class
- out_ebreak  out  1  ebreak (0x00100073)
- out_illegal  out  1  unrecognised encoding

## Operation
- State: full flag, inst_q, pc_q. Decode is combinational from inst_q/pc_q.
- in_ready = !flush && (!full || out_ready). out_valid = full.
- Accept when in_valid && in_ready: inst_q<=in_inst, pc_q<=in_pc, full<=1.
- Drain when out_valid && out_ready and no accept same cycle: full<=0; inst_q/pc_q unchanged.
- Simultaneous drain and accept: full stays 1, new instruction loaded (no bubble).
- flush: full<=0; in_valid that cycle ignored; inst_q/pc_q unchanged.
- Immediates per format: I, S, B (bit0=0), U (low 12 bits 0), J (bit0=0); R-type imm=0.
- R-type: funct7 0x00 or 0x20 (only with ADD->SUB, SRL->SRA) else illegal. I-type shifts: funct7 0x00 (SRLI/SLLI) or 0x20 (SRAI only).
- LUI: PASS_B, src_b_imm. AUIPC: ADD, src_a_pc, src_b_imm. JAL/JALR: rf_wen, link computed by EXU.
- Loads/stores/JALR: ALU ADD, src_b_imm.
- Illegal: opcode outside {LUI,AUIPC,JAL,JALR,BRANCH,LOAD,STORE,OP-IMM,OP,SYSTEM}, bad funct7, SYSTEM other than ebreak/ecall. Illegal forces rf_wen, mem_ren, mem_wen, branch, jal, jalr to 0.

## Timing
- Reset: full=0, inst_q=0x00000013 (NOP), pc_q=0; all decoded outputs thus zero (alu_op ADD, rf_wen 0, src_b_imm 1, illegal 0); out_valid=0; in_ready=1.
- Latency: accepted at edge N -> out_valid high in cycle N+1.
- Throughput one instruction/cycle with out_ready held 1.
- Outputs stable while out_valid && !out_ready.
- Reset mid-transfer drops held instruction; no output pulse.

## Configuration
- RV32E_REGS_EN defined: any rs1/rs2/rd index >=16 used by the instruction format sets out_illegal=1 (and suppresses writes as above).
- Undefined: full 32-register RV32I; index bit 4 never causes illegal.

## Structure
- Shared package: opcode constants, ALU op encodings, NOP constant, funct7 constants.
- One sub-module natural: imm_gen (combinational, inst -> 32-bit imm by format).

## Test plan
- Reset, then in_inst=0x00500093 (addi x1,x0,5), pc=0x80000000 -> next cycle out_valid=1, rd=1, rs1=0, imm=5, alu ADD, src_b_imm=1, rf_wen=1.
- in_inst=0xFE208EE3 (beq x1,x2,-4) -> branch=1, imm=0xFFFFFFFC, rs1=1, rs2=2, funct3=0, rf_wen=0.
- in_inst=0x123452B7 (lui x5) -> rd=5, imm=0x12345000, alu PASS_B.
- out_ready=0 with full, in_valid=1 -> in_ready=0, outputs held; raise out_ready with in_valid -> new instruction next cycle, no bubble.
- flush with full=1 and in_valid=1 -> out_valid=0 next cycle, incoming dropped.
- 0x00000833 (add x16) -> illegal=1 with RV32E_REGS_EN, legal rd=16 without; 0x00100073 -> ebreak=1.
